stream_mux_ctrl: RTL and testbench

Packet-granular scheduler for the stream mux that merges the packet+metadata path with the user-injection path onto one Avalon-ST output. It arbitrates whole packets between the two sources using weighted round-robin, holds the grant until EOP, and pops one metadata word per packet. It generates the mux select and all ready/valid gating, drops malformed packets, and keeps per-source statistics.

---
 rtl/stream_mux_ctrl_pkg.sv | 22 ++
 rtl/stream_mux_ctrl_if.sv | 36 +++
 rtl/wrr_arb2.sv | 66 ++++++
 rtl/stream_mux_ctrl.sv | 149 ++++++++++++++
 tb/tb_stream_mux_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_mux_ctrl_pkg.sv
// Shared types and constants for the stream mux packet scheduler.
package stream_mux_ctrl_pkg;

    // Scheduler states: idle/arbitrating, forwarding a packet, or discarding a malformed one.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PKT      = 3'd1,
        ST_USR      = 3'd2,
        ST_DROP_PKT = 3'd3,
        ST_DROP_USR = 3'd4
    } state_e;

    // Mux select encoding seen by the datapath.
    localparam logic SEL_PKT = 1'b0;
    localparam logic SEL_USR = 1'b1;

    // Default weights give plain alternation under contention.
    localparam int DEF_PKT_WEIGHT = 1;
    localparam int DEF_USR_WEIGHT = 1;
    localparam int DEF_CNT_W      = 32;

endpackage

// File: rtl/stream_mux_ctrl_if.sv
// Handshake bundle between the two input streams, the metadata FIFO,
// the downstream sink and the scheduler.
interface stream_mux_ctrl_if;

    logic pkt_valid;
    logic pkt_sop;
    logic pkt_eop;
    logic pkt_ready;
    logic meta_valid;
    logic meta_ready;
    logic usr_valid;
    logic usr_sop;
    logic usr_eop;
    logic usr_ready;
    logic out_ready;
    logic out_almost_full;
    logic out_valid;
    logic sel;

    // Environment side: sources, metadata FIFO and downstream sink.
    modport master (
        output pkt_valid, pkt_sop, pkt_eop, meta_valid,
        output usr_valid, usr_sop, usr_eop,
        output out_ready, out_almost_full,
        input  pkt_ready, meta_ready, usr_ready, out_valid, sel
    );

    // Scheduler side.
    modport slave (
        input  pkt_valid, pkt_sop, pkt_eop, meta_valid,
        input  usr_valid, usr_sop, usr_eop,
        input  out_ready, out_almost_full,
        output pkt_ready, meta_ready, usr_ready, out_valid, sel
    );

endinterface

// File: rtl/wrr_arb2.sv
// Two-way weighted round-robin arbiter. Grants are combinational from the
// eligibility bits; credits and turn only move on a contended, strobed grant,
// so an uncontended source never consumes the other side's share.
module wrr_arb2 #(
    parameter int W0 = 1,
    parameter int W1 = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig_i,
    input  logic       strobe_i,
    output logic [1:0] gnt_o
);

    localparam logic [7:0] W0_C = 8'(W0);
    localparam logic [7:0] W1_C = 8'(W1);

    logic       turn_q, turn_d;
    logic [7:0] cred0_q, cred0_d;
    logic [7:0] cred1_q, cred1_d;
    logic       contended;

    assign contended = elig_i[0] & elig_i[1];

    // Grant selection and credit/turn bookkeeping for contended grants.
    always_comb begin
        gnt_o   = elig_i;
        turn_d  = turn_q;
        cred0_d = cred0_q;
        cred1_d = cred1_q;
        if (contended) begin
            gnt_o = turn_q ? 2'b10 : 2'b01;
            if (strobe_i) begin
                if (!turn_q) begin
                    if (cred0_q == 8'd1) begin
                        cred0_d = W0_C;
                        turn_d  = 1'b1;
                    end else begin
                        cred0_d = cred0_q - 8'd1;
                    end
                end else begin
                    if (cred1_q == 8'd1) begin
                        cred1_d = W1_C;
                        turn_d  = 1'b0;
                    end else begin
                        cred1_d = cred1_q - 8'd1;
                    end
                end
            end
        end
    end

    // Credit and turn registers; turn starts with the packet path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            turn_q  <= 1'b0;
            cred0_q <= W0_C;
            cred1_q <= W1_C;
        end else begin
            turn_q  <= turn_d;
            cred0_q <= cred0_d;
            cred1_q <= cred1_d;
        end
    end

endmodule

// File: rtl/stream_mux_ctrl.sv
// Packet-granular scheduler merging the packet+metadata path and the user
// injection path onto one output stream. Holds each grant until EOP, pops one
// metadata word per forwarded packet, discards headless packets and counts
// forwarded/dropped packets per path.
module stream_mux_ctrl
    import stream_mux_ctrl_pkg::*;
#(
    parameter int PKT_WEIGHT = DEF_PKT_WEIGHT,
    parameter int USR_WEIGHT = DEF_USR_WEIGHT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    stream_mux_ctrl_if.slave bus,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] usr_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e     state_q;
    logic       sel_q;
    logic       first_q;
    logic       pkt_elig, usr_elig;
    logic       grant_stb;
    logic [1:0] gnt;
    logic       out_vld, pkt_rdy, usr_rdy, meta_rdy;
    logic       pkt_fire, usr_fire;
    logic       pkt_done, usr_done, drop_done;

    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] usr_cnt_q, usr_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // A packet head may only be granted when it starts a packet, its metadata
    // is present and the sink has room for a whole new packet.
    assign pkt_elig  = bus.pkt_valid & bus.pkt_sop & bus.meta_valid & ~bus.out_almost_full;
    assign usr_elig  = bus.usr_valid & bus.usr_sop & ~bus.out_almost_full;
    assign grant_stb = (state_q == ST_IDLE);

    wrr_arb2 #(
        .W0 (PKT_WEIGHT),
        .W1 (USR_WEIGHT)
    ) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .elig_i   ({usr_elig, pkt_elig}),
        .strobe_i (grant_stb),
        .gnt_o    (gnt)
    );

    // Ready/valid gating follows the owner of the output; drops sink beats freely.
    always_comb begin
        out_vld  = 1'b0;
        pkt_rdy  = 1'b0;
        usr_rdy  = 1'b0;
        meta_rdy = 1'b0;
        case (state_q)
            ST_PKT: begin
                out_vld  = bus.pkt_valid;
                pkt_rdy  = bus.out_ready;
                meta_rdy = bus.out_ready & bus.pkt_valid & first_q;
            end
            ST_USR: begin
                out_vld = bus.usr_valid;
                usr_rdy = bus.out_ready;
            end
            ST_DROP_PKT: pkt_rdy = 1'b1;
            ST_DROP_USR: usr_rdy = 1'b1;
            default: ;
        endcase
    end

    assign pkt_fire  = bus.pkt_valid & pkt_rdy;
    assign usr_fire  = bus.usr_valid & usr_rdy;
    assign pkt_done  = (state_q == ST_PKT) & pkt_fire & bus.pkt_eop;
    assign usr_done  = (state_q == ST_USR) & usr_fire & bus.usr_eop;
    assign drop_done = ((state_q == ST_DROP_PKT) & pkt_fire & bus.pkt_eop) |
                       ((state_q == ST_DROP_USR) & usr_fire & bus.usr_eop);

    assign bus.out_valid  = out_vld;
    assign bus.pkt_ready  = pkt_rdy;
    assign bus.usr_ready  = usr_rdy;
    assign bus.meta_ready = meta_rdy;
    assign bus.sel        = sel_q;

    // Packet-level FSM: grant in IDLE, hold the owner until its EOP fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_PKT;
            first_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt[0]) begin
                        state_q <= ST_PKT;
                        sel_q   <= SEL_PKT;
                        first_q <= 1'b1;
                    end else if (gnt[1]) begin
                        state_q <= ST_USR;
                        sel_q   <= SEL_USR;
                    end else if (bus.pkt_valid & ~bus.pkt_sop) begin
                        state_q <= ST_DROP_PKT;
                    end else if (bus.usr_valid & ~bus.usr_sop) begin
                        state_q <= ST_DROP_USR;
                    end
                end
                ST_PKT: begin
                    if (pkt_fire) first_q <= 1'b0;
                    if (pkt_done) state_q <= ST_IDLE;
                end
                ST_USR: begin
                    if (usr_done) state_q <= ST_IDLE;
                end
                ST_DROP_PKT, ST_DROP_USR: begin
                    if (drop_done) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Statistics increment once per completed (or discarded) packet and wrap.
    always_comb begin
        pkt_cnt_d  = pkt_done  ? pkt_cnt_q  + CNT_ONE : pkt_cnt_q;
        usr_cnt_d  = usr_done  ? usr_cnt_q  + CNT_ONE : usr_cnt_q;
        drop_cnt_d = drop_done ? drop_cnt_q + CNT_ONE : drop_cnt_q;
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            usr_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            usr_cnt_q  <= usr_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pkt_cnt  = pkt_cnt_q;
    assign usr_cnt  = usr_cnt_q;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_stream_mux_ctrl.sv
// Bench for stream_mux_ctrl: directed scenarios plus randomized traffic,
// all checked every cycle against a packet-level reference model.
module tb_stream_mux_ctrl;

    localparam int PW = 2;
    localparam int UW = 1;
    localparam int CW = 4;
    localparam int CMOD = 1 << CW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_mux_ctrl_if bus ();
    logic [CW-1:0] pkt_cnt, usr_cnt, drop_cnt;

    stream_mux_ctrl #(
        .PKT_WEIGHT (PW),
        .USR_WEIGHT (UW),
        .CNT_W      (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .pkt_cnt  (pkt_cnt),
        .usr_cnt  (usr_cnt),
        .drop_cnt (drop_cnt)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source streams: one entry per beat, head at index 0.
    typedef struct packed {
        logic sop;
        logic eop;
    } beat_t;
    beat_t pq[$];
    beat_t uq[$];

    bit rnd = 0;
    int meta_mode = 0;   // 0: always present, 1: absent, 2: random but held once granted
    bit p_en = 1, u_en = 1, drv_ordy = 1, drv_af = 0;
    bit p_pop = 0, u_pop = 0;

    // Reference model: who owns the output, WRR credits and running totals.
    int m_own;           // 0 none, 1 pkt, 2 usr, 3 dropping pkt, 4 dropping usr
    bit m_turn;
    int m_cred[2];
    bit m_first, m_sel;
    int m_pc, m_uc, m_dc;

    // Per-cycle observations for the directed scenarios.
    bit sn_ofire, sn_oeop, sn_sel, sn_mpop, sn_ov, sn_ur, sn_ordy;

    task automatic model_reset();
        m_own = 0; m_turn = 0; m_cred[0] = PW; m_cred[1] = UW;
        m_first = 0; m_sel = 0; m_pc = 0; m_uc = 0; m_dc = 0;
    endtask

    task automatic push_pkt(input bit to_usr, input int len, input bit bad);
        for (int i = 0; i < len; i++) begin
            beat_t b;
            b.sop = (i == 0) && !bad;
            b.eop = (i == len - 1);
            if (to_usr) uq.push_back(b);
            else        pq.push_back(b);
        end
    endtask

    task automatic drive();
        if (rnd) begin
            p_en     = ($urandom_range(0, 3) != 0);
            u_en     = ($urandom_range(0, 3) != 0);
            drv_ordy = ($urandom_range(0, 3) != 0);
            drv_af   = ($urandom_range(0, 4) == 0);
        end
        bus.pkt_valid = p_en && (pq.size() > 0);
        bus.pkt_sop   = (pq.size() > 0) ? pq[0].sop : 1'b0;
        bus.pkt_eop   = (pq.size() > 0) ? pq[0].eop : 1'b0;
        bus.usr_valid = u_en && (uq.size() > 0);
        bus.usr_sop   = (uq.size() > 0) ? uq[0].sop : 1'b0;
        bus.usr_eop   = (uq.size() > 0) ? uq[0].eop : 1'b0;
        bus.out_ready = drv_ordy;
        bus.out_almost_full = drv_af;
        case (meta_mode)
            0: bus.meta_valid = 1'b1;
            1: bus.meta_valid = 1'b0;
            default: bus.meta_valid = (m_own == 1 && m_first) ? 1'b1 : 1'($urandom_range(0, 1));
        endcase
    endtask

    // Advance one clock: retire beats popped in the cycle just ended, present the next heads.
    task automatic step();
        @(posedge clk);
        #1;
        if (p_pop) void'(pq.pop_front());
        if (u_pop) void'(uq.pop_front());
        p_pop = 0;
        u_pop = 0;
        drive();
    endtask

    task automatic cyc_obs();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pq.delete();
        uq.delete();
        rnd = 0; meta_mode = 0;
        p_en = 1; u_en = 1; drv_ordy = 1; drv_af = 0;
        p_pop = 0; u_pop = 0;
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Compare process: every cycle out of reset, DUT outputs vs model, then model advances.
    logic c_pv, c_ps, c_pe, c_uv, c_us, c_ue, c_mv, c_or, c_af;
    logic e_ov, e_pr, e_mr, e_ur;
    always @(negedge clk) begin
        if (rst_n) begin
            c_pv = bus.pkt_valid; c_ps = bus.pkt_sop; c_pe = bus.pkt_eop;
            c_uv = bus.usr_valid; c_us = bus.usr_sop; c_ue = bus.usr_eop;
            c_mv = bus.meta_valid; c_or = bus.out_ready; c_af = bus.out_almost_full;

            e_ov = (m_own == 1) ? c_pv : (m_own == 2) ? c_uv : 1'b0;
            e_pr = (m_own == 1) ? c_or : (m_own == 3);
            e_mr = (m_own == 1) && c_or && c_pv && m_first;
            e_ur = (m_own == 2) ? c_or : (m_own == 4);

            check("handshake{ov,pr,mr,ur,sel}",
                  32'({bus.out_valid, bus.pkt_ready, bus.meta_ready, bus.usr_ready, bus.sel}),
                  32'({e_ov, e_pr, e_mr, e_ur, m_sel}));
            check("pkt_cnt", 32'(pkt_cnt), m_pc % CMOD);
            check("usr_cnt", 32'(usr_cnt), m_uc % CMOD);
            check("drop_cnt", 32'(drop_cnt), m_dc % CMOD);

            sn_ov    = bus.out_valid;
            sn_ofire = bus.out_valid && c_or;
            sn_oeop  = sn_ofire && (bus.sel ? c_ue : c_pe);
            sn_sel   = bus.sel;
            sn_mpop  = bus.meta_ready && c_mv;
            sn_ur    = bus.usr_ready;
            sn_ordy  = c_or;
            p_pop    = c_pv && bus.pkt_ready;
            u_pop    = c_uv && bus.usr_ready;

            case (m_own)
                0: begin : arbitrate
                    bit pel, uel;
                    int side;
                    pel = c_pv && c_ps && c_mv && !c_af;
                    uel = c_uv && c_us && !c_af;
                    side = -1;
                    if (pel && uel) begin
                        side = int'(m_turn);
                        m_cred[side]--;
                        if (m_cred[side] == 0) begin
                            m_cred[side] = (side == 1) ? UW : PW;
                            m_turn = !m_turn;
                        end
                    end else if (pel) side = 0;
                    else if (uel) side = 1;
                    else if (c_pv && !c_ps) m_own = 3;
                    else if (c_uv && !c_us) m_own = 4;
                    if (side >= 0) begin
                        m_own = side + 1;
                        m_sel = (side == 1);
                        m_first = 1;
                    end
                end
                1: if (c_pv && c_or) begin
                    m_first = 0;
                    if (c_pe) begin m_pc++; m_own = 0; end
                end
                2: if (c_uv && c_or && c_ue) begin m_uc++; m_own = 0; end
                3: if (c_pv && c_pe) begin m_dc++; m_own = 0; end
                4: if (c_uv && c_ue) begin m_dc++; m_own = 0; end
                default: m_own = 0;
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit done;
        int n, last_eop, mpops, sel_moves, nf, stall_left, recv[4];
        logic [5:0] seq;
        bit ov_seen;

        // Reset values while held in reset, with sources already offering data.
        model_reset();
        pq.delete(); uq.delete();
        push_pkt(0, 2, 0); push_pkt(1, 2, 0);
        drive();
        #3;
        check("reset_outputs", 32'({bus.out_valid, bus.pkt_ready, bus.meta_ready, bus.usr_ready, bus.sel}), 0);
        check("reset_counters", 32'({pkt_cnt, usr_cnt, drop_cnt}), 0);

        // Single path: 3 packets of 4 beats, no backpressure.
        do_reset();
        for (int k = 0; k < 3; k++) push_pkt(0, 4, 0);
        drive();
        n = 0; last_eop = -1; mpops = 0; sel_moves = 0; done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            cyc_obs();
            if (sn_oeop) last_eop = n;
            if (sn_mpop) mpops++;
            if (sn_sel) sel_moves++;
            n++;
            step();
            if (pq.size() == 0) done = 1;
        end
        if (!done) check("single_path_timeout", 1, 0);
        check("single_path_cycles", last_eop + 1, 15);
        check("single_path_pkt_cnt", 32'(pkt_cnt), 3);
        check("single_path_meta_pops", mpops, 3);
        check("single_path_sel_moves", sel_moves, 0);

        // Weighted contention 2:1 with single-beat packets on both sides.
        do_reset();
        for (int k = 0; k < 8; k++) begin push_pkt(0, 1, 0); push_pkt(1, 1, 0); end
        drive();
        seq = '0; nf = 0;
        for (int i = 0; i < 40 && nf < 6; i++) begin
            cyc_obs();
            if (sn_ofire) begin seq = {seq[4:0], sn_sel}; nf++; end
            step();
        end
        if (nf < 6) check("wrr_timeout", 1, 0);
        check("wrr_grant_sequence", 32'(seq), 32'(6'b001001));
        check("wrr_pkt_cnt", 32'(pkt_cnt), 4);
        check("wrr_usr_cnt", 32'(usr_cnt), 2);

        // Backpressure: 4-beat user packet stalled for 5 cycles after its first beat.
        do_reset();
        push_pkt(1, 4, 0);
        drive();
        nf = 0; stall_left = 5; done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            cyc_obs();
            if (!sn_ordy) check("bp_usr_ready_low", sn_ur, 0);
            if (sn_ofire && nf < 4) begin recv[nf] = 4 - uq.size(); nf++; end
            if (nf == 4) done = 1;
            else begin
                if (nf >= 1 && stall_left > 0) begin drv_ordy = 0; stall_left--; end
                else drv_ordy = 1;
                step();
            end
        end
        if (!done) check("bp_timeout", 1, 0);
        check("bp_stall_applied", stall_left, 0);
        for (int k = 0; k < 4; k++) check("bp_beat_order", recv[k], k);
        step();
        check("bp_usr_cnt", 32'(usr_cnt), 1);

        // Almost-full: raised mid-packet, then held with both sides eligible.
        do_reset();
        push_pkt(0, 4, 0); push_pkt(0, 1, 0); push_pkt(1, 1, 0);
        drive();
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc_obs();
            if (sn_ofire) drv_af = 1;
            if (sn_oeop) done = 1;
            step();
        end
        if (!done) check("af_timeout", 1, 0);
        check("af_pkt_completes", 32'(pkt_cnt), 1);
        for (int i = 0; i < 4; i++) begin
            cyc_obs();
            check("af_hold_no_grant", sn_ov, 0);
            if (i == 3) drv_af = 0;
            step();
        end
        cyc_obs();
        check("af_release_idle", sn_ov, 0);
        step();
        cyc_obs();
        check("af_release_grant", sn_ov, 1);
        step();

        // Headless packet: three beats without SOP are discarded.
        do_reset();
        push_pkt(0, 3, 1);
        drive();
        ov_seen = 0; done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            cyc_obs();
            if (sn_ov) ov_seen = 1;
            step();
            if (pq.size() == 0) done = 1;
        end
        if (!done) check("drop_timeout", 1, 0);
        check("drop_no_out_valid", ov_seen, 0);
        check("drop_cnt_one", 32'(drop_cnt), 1);
        check("drop_pkt_cnt_zero", 32'(pkt_cnt), 0);

        // Missing metadata: packet head waits, user path is granted.
        do_reset();
        meta_mode = 1;
        push_pkt(0, 1, 0); push_pkt(1, 1, 0);
        drive();
        cyc_obs();
        step();
        check("nometa_sel_usr", 32'(bus.sel), 1);
        cyc_obs();
        check("nometa_usr_fires", sn_ofire, 1);
        step();

        // Reset asserted in the middle of a user packet.
        do_reset();
        push_pkt(1, 1, 0); push_pkt(1, 4, 0);
        drive();
        repeat (4) begin cyc_obs(); step(); end
        check("pre_reset_sel", 32'(bus.sel), 1);
        check("pre_reset_usr_cnt", 32'(usr_cnt), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 32'({bus.out_valid, bus.pkt_ready, bus.meta_ready, bus.usr_ready, bus.sel}), 0);
        check("midreset_counters", 32'({pkt_cnt, usr_cnt, drop_cnt}), 0);

        // Counter wrap: 17 user packets on a 4-bit counter.
        do_reset();
        for (int k = 0; k < 17; k++) push_pkt(1, 1, 0);
        drive();
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            cyc_obs();
            step();
            if (uq.size() == 0) done = 1;
        end
        if (!done) check("wrap_timeout", 1, 0);
        check("wrap_usr_cnt", 32'(usr_cnt), 1);

        // Randomized traffic: gaps, backpressure, almost-full, headless packets.
        do_reset();
        rnd = 1;
        meta_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            if (pq.size() < 6) push_pkt(0, $urandom_range(1, 5), $urandom_range(0, 9) == 0);
            if (uq.size() < 6) push_pkt(1, $urandom_range(1, 5), $urandom_range(0, 9) == 0);
            cyc_obs();
            step();
        end
        rnd = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
